sdram_ring_client: RTL and testbench

- Initiator on the sdram controller's request/response port (avalid/aready/awe/aaddr/adata in, bvalid/bdata back).
- Uses external SDRAM as a large circular FIFO for the capture path: 16-bit samples in, the same samples out in order.
- Sits between the sample capture front end (write side) and the host readout logic (read side).
- Tracks in-flight requests so that unflow-controlled responses (bvalid has no ready) are never dropped.

---
 rtl/sdram_ring_client_pkg.sv | 13 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/sdram_ring_client.sv | 138 +++++++++++++
 tb/tb_sdram_ring_client.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ring_client_pkg.sv
// Shared widths and the request record for the SDRAM ring client.
package sdram_ring_client_pkg;

  localparam int unsigned DataW     = 16;
  localparam int unsigned CtrlAddrW = 24;

  typedef struct packed {
    logic                 we;
    logic [CtrlAddrW-1:0] addr;
    logic [DataW-1:0]     data;
  } req_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != CntW'(Depth));
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/sdram_ring_client.sv
// Uses SDRAM behind a request/response controller port as a large circular sample FIFO.
module sdram_ring_client
  import sdram_ring_client_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_OUTST = 8,
  parameter int unsigned RD_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataW-1:0]     s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DataW-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [ADDR_W:0]      level,
  output logic                 avalid,
  input  logic                 aready,
  output logic                 awe,
  output logic [CtrlAddrW-1:0] aaddr,
  output logic [DataW-1:0]     adata,
  input  logic                 bvalid,
  input  logic [DataW-1:0]     bdata
);

  localparam int unsigned OutW    = $clog2(MAX_OUTST) + 1;
  localparam int unsigned OutSumW = OutW + 1;
  localparam int unsigned RdW     = $clog2(RD_DEPTH) + 1;
  localparam int unsigned RdSumW  = RdW + 1;
  localparam int unsigned LvlW    = ADDR_W + 1;

  req_t              req_q, req_d;
  logic              avalid_q, avalid_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [RdW-1:0]    rd_pend_q, rd_pend_d;

  logic [OutW-1:0]   tag_cnt;
  logic              tag_head, tag_empty, tag_pop, rsp_rd;
  logic [RdW-1:0]    of_cnt;
  logic              of_empty, of_pop;
  logic              accept, slot_free, outst_ok, wr_cand, rd_cand, load_wr, load_rd;

  always_comb begin
    accept    = avalid_q && aready;
    slot_free = !avalid_q || accept;
    // The request sitting in the register counts as outstanding: it is
    // either waiting for aready or about to land in the tag FIFO.
    outst_ok  = (OutSumW'(tag_cnt) + OutSumW'(avalid_q)) < OutSumW'(MAX_OUTST);
    wr_cand   = s_valid && !level_q[ADDR_W];
    // rd_pend counts reads from load to response, so buffered plus in-flight
    // words can never exceed the output FIFO depth.
    rd_cand   = (level_q != '0) &&
                ((RdSumW'(of_cnt) + RdSumW'(rd_pend_q)) < RdSumW'(RD_DEPTH));
    load_wr   = slot_free && outst_ok && wr_cand;
    load_rd   = slot_free && outst_ok && !wr_cand && rd_cand;
    tag_pop   = bvalid && !tag_empty;
    rsp_rd    = tag_pop && !tag_head;
    of_pop    = o_ready && !of_empty;

    req_d     = req_q;
    avalid_d  = avalid_q && !accept;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (load_wr) begin
      req_d    = '{we: 1'b1, addr: CtrlAddrW'(wr_ptr_q), data: s_data};
      avalid_d = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      level_d  = level_q + LvlW'(1);
    end else if (load_rd) begin
      req_d    = '{we: 1'b0, addr: CtrlAddrW'(rd_ptr_q), data: '0};
      avalid_d = 1'b1;
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      level_d  = level_q - LvlW'(1);
    end
    rd_pend_d = rd_pend_q + RdW'(load_rd) - RdW'(rsp_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      avalid_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_pend_q <= '0;
    end else begin
      req_q     <= req_d;
      avalid_q  <= avalid_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  sync_fifo #(
    .Width (1),
    .Depth (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i (req_q.we),
    .pop_i   (tag_pop),
    .rdata_o (tag_head),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  sync_fifo #(
    .Width (DataW),
    .Depth (RD_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_rd),
    .wdata_i (bdata),
    .pop_i   (of_pop),
    .rdata_o (o_data),
    .empty_o (of_empty),
    .count_o (of_cnt)
  );

  assign s_ready = load_wr;
  assign o_valid = !of_empty;
  assign level   = level_q;
  assign avalid  = avalid_q;
  assign awe     = req_q.we;
  assign aaddr   = req_q.addr;
  assign adata   = req_q.data;

  // A response with nothing in flight is a controller protocol error; it is dropped.
  bvalid_has_tag_a: assert property (@(posedge clk) disable iff (rst) !(bvalid && tag_empty));

endmodule

// File: tb/tb_sdram_ring_client.sv
// Bench for sdram_ring_client: in-order controller model plus sample scoreboard.
module tb_sdram_ring_client;

  localparam int unsigned AW   = 5;
  localparam int unsigned RING = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [AW:0] level;
  logic        avalid, awe;
  logic        aready = 1'b0;
  logic [23:0] aaddr;
  logic [15:0] adata;
  logic        bvalid = 1'b0;
  logic [15:0] bdata = '0;

  sdram_ring_client #(
    .ADDR_W    (AW),
    .MAX_OUTST (8),
    .RD_DEPTH  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .level   (level),
    .avalid  (avalid),
    .aready  (aready),
    .awe     (awe),
    .aaddr   (aaddr),
    .adata   (adata),
    .bvalid  (bvalid),
    .bdata   (bdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] data;
    int          due;
  } rsp_t;

  typedef struct {
    logic [15:0] din;
    logic [23:0] exp_addr;
    logic [AW:0] exp_level;
  } vec_t;

  int          ntotal = 0, npass = 0, cyc = 0, lat = 4;
  bit          rand_a = 1'b0, rand_o = 1'b0, ready_fix = 1'b1, o_ready_fix = 1'b0;
  int          n_wacc = 0, n_racc = 0, n_out = 0, wr_m = 0, rd_m = 0;
  logic [23:0] last_raddr = '0;
  logic [15:0] last_odata = '0;
  logic [15:0] mem [RING];
  logic [15:0] exp_q [$];
  rsp_t        pend_q [$];
  rsp_t        r;
  bit          stall_v = 1'b0;
  logic [41:0] stall_req = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: everything sampled at negedge is what the next posedge will consume.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_m = 0; rd_m = 0; n_wacc = 0; n_racc = 0; n_out = 0; stall_v = 1'b0;
    end else begin
      if (stall_v) check("req_stable", 64'({avalid, awe, aaddr, adata}), 64'(stall_req));
      stall_v   = avalid && !aready;
      stall_req = {avalid, awe, aaddr, adata};
      if (avalid && aready) begin
        if (awe) begin
          check("waddr", 64'(aaddr), 64'(wr_m));
          mem[aaddr[AW-1:0]] = adata;
          wr_m = (wr_m + 1) % RING;
          n_wacc++;
          pend_q.push_back('{we: 1'b1, data: 16'h0, due: cyc + lat});
        end else begin
          check("raddr", 64'(aaddr), 64'(rd_m));
          rd_m = (rd_m + 1) % RING;
          n_racc++;
          last_raddr = aaddr;
          pend_q.push_back('{we: 1'b0, data: mem[aaddr[AW-1:0]], due: cyc + lat});
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      if (o_valid && o_ready) begin
        n_out++;
        last_odata = o_data;
        if (exp_q.size() == 0) begin
          ntotal++;
          $display("FAIL o_extra: got %0h expected no word", o_data);
        end else begin
          check("o_data", 64'(o_data), 64'(exp_q.pop_front()));
        end
      end
    end
    cyc++;
  end

  // Controller and consumer model, driven just after each posedge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pend_q.delete();
      bvalid = 1'b0; aready = 1'b0; o_ready = 1'b0;
    end else begin
      aready  = rand_a ? 1'($urandom_range(0, 1)) : ready_fix;
      o_ready = rand_o ? 1'($urandom_range(0, 1)) : o_ready_fix;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        bvalid = 1'b1;
        bdata  = r.we ? 16'($urandom) : r.data;
      end else begin
        bvalid = 1'b0;
      end
    end
  end

  task automatic send(input logic [15:0] w);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    check("send_hs", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avalid"}, 64'(avalid), 64'd0);
    check({tag, "_awe"}, 64'(awe), 64'd0);
    check({tag, "_aaddr"}, 64'(aaddr), 64'd0);
    check({tag, "_adata"}, 64'(adata), 64'd0);
    check({tag, "_o_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_o_data"}, 64'(o_data), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_level"}, 64'(level), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   c0;
    vecs[0] = '{din: 16'h1111, exp_addr: 24'd0, exp_level: 6'd1};
    vecs[1] = '{din: 16'h2222, exp_addr: 24'd1, exp_level: 6'd2};
    vecs[2] = '{din: 16'h3333, exp_addr: 24'd2, exp_level: 6'd3};
    vecs[3] = '{din: 16'h4444, exp_addr: 24'd3, exp_level: 6'd4};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Four writes with the consumer stalled, then the four reads.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].din);
      check("t1_awe", 64'(awe), 64'd1);
      check("t1_aaddr", 64'(aaddr), 64'(vecs[i].exp_addr));
      check("t1_adata", 64'(adata), 64'(vecs[i].din));
      check("t1_level", 64'(level), 64'(vecs[i].exp_level));
    end
    s_valid = 1'b0;
    for (int i = 0; i < 50 && n_racc < 4; i++) @(negedge clk);
    check("t1_nreads", 64'(n_racc), 64'd4);
    check("t1_level0", 64'(level), 64'd0);
    check("t1_last_raddr", 64'(last_raddr), 64'd3);
    repeat (10) @(negedge clk);
    check("t1_o_valid", 64'(o_valid), 64'd1);
    check("t1_o_head", 64'(o_data), 64'h1111);
    @(posedge clk); #1 o_ready_fix = 1'b1;
    for (int i = 0; i < 50 && n_out < 4; i++) @(negedge clk);
    check("t1_nout", 64'(n_out), 64'd4);

    // Stalled consumer: reads stop at the output buffer depth.
    o_ready_fix = 1'b0; lat = 2;
    do_reset();
    for (int i = 0; i < 20; i++) send(16'h0100 + 16'(i * 3));
    s_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("t3_nreads", 64'(n_racc), 64'd8);
    check("t3_level", 64'(level), 64'd12);
    check("t3_o_valid", 64'(o_valid), 64'd1);
    @(posedge clk); #1 o_ready_fix = 1'b1;
    for (int i = 0; i < 300 && n_out < 20; i++) @(negedge clk);
    check("t3_nout", 64'(n_out), 64'd20);
    check("t3_nreads_all", 64'(n_racc), 64'd20);
    check("t3_level0", 64'(level), 64'd0);

    // Full ring (32 words here): back-pressure, then wrap to address 0.
    o_ready_fix = 1'b0; lat = 1;
    do_reset();
    for (int i = 0; i < 32; i++) send(16'hA000 + 16'(i));
    check("t4_level_full", 64'(level), 64'd32);
    s_data = 16'hA020;
    @(negedge clk);
    check("t4_s_ready_full", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    send(16'hA020);
    check("t4_wrap_awe", 64'(awe), 64'd1);
    check("t4_wrap_aaddr", 64'(aaddr), 64'd0);
    check("t4_wrap_adata", 64'(adata), 64'hA020);
    s_valid = 1'b0;
    o_ready_fix = 1'b1;
    for (int i = 0; i < 400 && n_out < 33; i++) @(negedge clk);
    check("t4_nout", 64'(n_out), 64'd33);
    check("t4_level0", 64'(level), 64'd0);

    // Writes beat pending reads every cycle.
    lat = 3;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 15; i++) send(16'h5000 + 16'(i));
    check("t5_cycles", 64'(cyc - c0), 64'd15);
    check("t5_no_reads", 64'(n_racc), 64'd0);
    check("t5_level", 64'(level), 64'd15);
    s_valid = 1'b0;
    for (int i = 0; i < 300 && n_out < 15; i++) @(negedge clk);
    check("t5_nout", 64'(n_out), 64'd15);
    check("t5_nreads", 64'(n_racc), 64'd15);

    // Random traffic with a 50% aready and a 4-cycle controller.
    lat = 4; rand_a = 1'b1; rand_o = 1'b1;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      send(16'($urandom));
    end
    s_valid = 1'b0;
    for (int i = 0; i < 20000 && n_out < 1000; i++) @(negedge clk);
    check("t2_nout", 64'(n_out), 64'd1000);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t2_level0", 64'(level), 64'd0);
    rand_a = 1'b0; rand_o = 1'b0;

    // Reset with requests still in flight.
    lat = 20; ready_fix = 1'b1; o_ready_fix = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) send(16'h7000 + 16'(i));
    s_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_inflight", 64'(n_wacc), 64'd3);
    #1 rst = 1'b1;
    #1 check_reset_outputs("t6_rst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    lat = 2; o_ready_fix = 1'b1;
    send(16'hBEEF);
    check("t6_aaddr", 64'(aaddr), 64'd0);
    check("t6_adata", 64'(adata), 64'hBEEF);
    s_valid = 1'b0;
    for (int i = 0; i < 100 && n_out < 1; i++) @(negedge clk);
    check("t6_nout", 64'(n_out), 64'd1);
    check("t6_raddr", 64'(last_raddr), 64'd0);
    check("t6_odata", 64'(last_odata), 64'hBEEF);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
